// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the analog mux SPI interface through a table of TX/RX addresses, settling and measuring at each step.
module mux_scan_sequencer #(
  parameter int DEPTH          = 16,
  parameter int SETTLE_CYCLES  = 500,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [15:0] cfg_data_i,
  input  logic [4:0]  num_steps_i,
  input  logic        loop_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  step_o,
  output logic        mux_en_o,
  input  logic        mux_done_i,
  output logic [3:0]  TX1_addr_o,
  output logic [3:0]  TX2_addr_o,
  output logic [3:0]  RX1_addr_o,
  output logic [3:0]  RX2_addr_o,
  output logic        meas_start_o,
  input  logic        meas_done_i
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_MUX, S_SETTLE, S_MEASURE, S_WAIT_MEAS, S_NEXT, S_DONE, S_ERROR
  } state_t;
  state_t          r_state, w_next;
  logic [15:0]     r_tab [DEPTH];
  logic [3:0]      r_step, w_step_nxt;
  logic [4:0]      r_num;
  logic            r_loop, r_err;
  logic [SW-1:0]   r_settle;
  logic [TW-1:0]   r_tmo;
  logic [15:0]     r_addr;
  logic            w_start_ok, w_last, w_tmo, w_settled, w_accept;
  assign w_start_ok = (num_steps_i != 5'd0) && (num_steps_i <= 5'(DEPTH));
  assign w_last     = {1'b0, r_step} == r_num - 5'd1;
  assign w_tmo      = r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign w_settled  = r_settle == SW'(SETTLE_CYCLES - 1);
  assign w_accept   = r_state == S_IDLE && w_next == S_LOAD;
  assign w_step_nxt = (r_state == S_NEXT && !w_last) ? r_step + 4'd1 : 4'd0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start_i) w_next = w_start_ok ? S_LOAD : S_ERROR;
      S_LOAD:      w_next = S_WAIT_MUX;
      // a done arriving together with the timeout still counts as success
      S_WAIT_MUX:  w_next = mux_done_i ? (SETTLE_CYCLES == 0 ? S_MEASURE : S_SETTLE) : w_tmo ? S_ERROR : S_WAIT_MUX;
      S_SETTLE:    if (w_settled) w_next = S_MEASURE;
      S_MEASURE:   w_next = S_WAIT_MEAS;
      S_WAIT_MEAS: w_next = meas_done_i ? S_NEXT : w_tmo ? S_ERROR : S_WAIT_MEAS;
      S_NEXT:      w_next = (!w_last || r_loop) ? S_LOAD : S_DONE;
      default:     w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_num    <= '0;
      r_loop   <= 1'b0;
      r_err    <= 1'b0;
      r_settle <= '0;
      r_tmo    <= '0;
      r_addr   <= '0;
    end else begin
      r_state  <= w_next;
      r_settle <= (r_state == S_SETTLE) ? r_settle + SW'(1) : '0;
      r_tmo    <= (r_state == S_WAIT_MUX || r_state == S_WAIT_MEAS) ? r_tmo + TW'(1) : '0;
      if (w_next == S_LOAD) begin
        r_step <= w_step_nxt;
        r_addr <= r_tab[w_step_nxt[AW-1:0]];
      end
      if (w_accept) begin
        r_num  <= num_steps_i;
        r_loop <= loop_i;
      end
      if (w_next == S_ERROR) r_err <= 1'b1;
      else if (w_accept) r_err <= 1'b0;
    end
  end
  always_ff @(posedge clk_i)
    if (cfg_we_i && r_state == S_IDLE && {1'b0, cfg_addr_i} < 5'(DEPTH))
      r_tab[cfg_addr_i[AW-1:0]] <= cfg_data_i;
  assign busy_o       = r_state != S_IDLE;
  assign done_o       = r_state == S_DONE;
  assign err_o        = r_err;
  assign step_o       = r_step;
  assign mux_en_o     = r_state == S_LOAD;
  assign meas_start_o = r_state == S_MEASURE;
  assign {TX1_addr_o, TX2_addr_o, RX1_addr_o, RX2_addr_o} = r_addr;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: randomized scoreboard bench with a step-list reference model for mux_scan_sequencer.
module tb_mux_scan_sequencer;
  localparam int SETTLE = 4;
  localparam int TMO    = 20;
  logic        clk_i = 0, rst_i = 1, cfg_we_i = 0, loop_i = 0, start_i = 0, abort_i = 0;
  logic        mux_done_i = 0, meas_done_i = 0;
  logic [3:0]  cfg_addr_i = 0;
  logic [15:0] cfg_data_i = 0;
  logic [4:0]  num_steps_i = 0;
  logic        busy_o, done_o, err_o, mux_en_o, meas_start_o;
  logic [3:0]  step_o, TX1_addr_o, TX2_addr_o, RX1_addr_o, RX2_addr_o;
  logic [15:0] w_addrs;
  logic [24:0] w_outs;
  int          checks = 0, failures = 0, cyc = 0, mux_cnt = 0, meas_cnt = 0;
  int          t_mux_en = 0, t_mux_done = 0, t_err = 0;
  bit          mux_resp = 1, meas_resp = 1, err_q = 0, chk_busy = 0;
  logic [15:0] tab [16];
  logic [21:0] sb [$];

  mux_scan_sequencer #(.DEPTH(16), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .num_steps_i(num_steps_i), .loop_i(loop_i),
    .start_i(start_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .step_o(step_o), .mux_en_o(mux_en_o), .mux_done_i(mux_done_i),
    .TX1_addr_o(TX1_addr_o), .TX2_addr_o(TX2_addr_o), .RX1_addr_o(RX1_addr_o),
    .RX2_addr_o(RX2_addr_o), .meas_start_o(meas_start_o), .meas_done_i(meas_done_i));

  assign w_addrs = {TX1_addr_o, TX2_addr_o, RX1_addr_o, RX2_addr_o};
  assign w_outs  = {busy_o, done_o, err_o, step_o, mux_en_o, meas_start_o, w_addrs};

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pop(logic [1:0] k, logic [19:0] v);
    logic [21:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%0h required=none", {k, v});
    end else begin
      e = sb.pop_front();
      chk("event", {10'd0, k, v}, {10'd0, e});
    end
  endtask

  // Event kinds: 0 = mux request {step, addresses}, 1 = done pulse, 2 = error rise
  always @(negedge clk_i) if (!rst_i) begin
    if (chk_busy) begin
      chk("busy_after_done", {31'd0, busy_o}, 0);
      chk_busy = 0;
    end
    if (mux_done_i) t_mux_done = cyc;
    if (mux_en_o) begin
      mux_cnt++;
      t_mux_en = cyc;
      pop(2'd0, {step_o, w_addrs});
    end
    if (meas_start_o) begin
      meas_cnt++;
      chk("settle_gap", cyc - t_mux_done, SETTLE + 1);
    end
    if (done_o) begin
      pop(2'd1, 20'd0);
      chk_busy = 1;
    end
    if (err_o && !err_q) begin
      pop(2'd2, 20'd0);
      t_err = cyc;
    end
    err_q = err_o;
  end

  always begin
    @(negedge clk_i);
    if (mux_en_o && mux_resp) begin
      repeat ($urandom_range(1, 4)) @(posedge clk_i);
      #1 mux_done_i = 1;
      @(posedge clk_i);
      #1 mux_done_i = 0;
    end
  end

  always begin
    @(negedge clk_i);
    if (meas_start_o && meas_resp) begin
      repeat ($urandom_range(1, 4)) @(posedge clk_i);
      #1 meas_done_i = 1;
      @(posedge clk_i);
      #1 meas_done_i = 0;
    end
  end

  task automatic push_pass(int ns, int nrun, bit with_done);
    for (int i = 0; i < nrun; i++) sb.push_back({2'd0, 4'(i % ns), tab[i % ns]});
    if (with_done) sb.push_back({2'd1, 20'd0});
  endtask

  task automatic wr(int a, logic [15:0] d, bit upd);
    @(posedge clk_i);
    #1 cfg_we_i = 1; cfg_addr_i = 4'(a); cfg_data_i = d;
    @(posedge clk_i);
    #1 cfg_we_i = 0;
    if (upd) tab[a] = d;
  endtask

  task automatic start(int ns, bit lp);
    @(posedge clk_i);
    #1 num_steps_i = 5'(ns); loop_i = lp; start_i = 1;
    @(posedge clk_i);
    #1 start_i = 0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    do begin
      @(negedge clk_i);
      #1 n++;
    end while (busy_o && n < 2000);
    chk(nm, {31'd0, busy_o}, 0);
    chk({nm, "_sb"}, sb.size(), 0);
  endtask

  task automatic wait_cnt(bit meas, int target);
    int n = 0;
    do begin
      @(negedge clk_i);
      #1 n++;
    end while ((meas ? meas_cnt : mux_cnt) < target && n < 2000);
    chk(meas ? "wait_meas" : "wait_mux", meas ? meas_cnt : mux_cnt, target);
  endtask

  task automatic abort_now(logic [15:0] hold);
    abort_i = 1;
    @(posedge clk_i);
    #1 abort_i = 0;
    @(negedge clk_i);
    chk("abort_idle", {31'd0, busy_o}, 0);
    chk("abort_addr_hold", {16'd0, w_addrs}, {16'd0, hold});
    repeat (10) @(negedge clk_i);
    chk("abort_sb", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ns, nrun, base;
    repeat (3) @(posedge clk_i);
    #1 chk("reset_outputs", {7'd0, w_outs}, 0);
    rst_i = 0;
    wr(0, 16'h1234, 1);
    wr(1, 16'h5678, 1);
    wr(2, 16'h9ABC, 1);
    // single pass
    push_pass(3, 3, 1);
    start(3, 0);
    wait_idle("single_pass");
    // continuous loop, abort after seven steps
    base = mux_cnt;
    push_pass(3, 7, 0);
    start(3, 1);
    wait_cnt(0, base + 7);
    abort_now(16'h1234);
    chk("abort_err", {31'd0, err_o}, 0);
    // mux never answers
    mux_resp = 0;
    push_pass(1, 1, 0);
    sb.push_back({2'd2, 20'd0});
    start(1, 0);
    wait_idle("timeout");
    chk("timeout_latency", t_err - t_mux_en, TMO + 1);
    chk("timeout_err", {31'd0, err_o}, 1);
    mux_resp = 1;
    push_pass(3, 3, 1);
    start(3, 0);
    chk("err_cleared", {31'd0, err_o}, 0);
    wait_idle("after_timeout");
    // bad step counts
    sb.push_back({2'd2, 20'd0});
    start(0, 0);
    wait_idle("zero_steps");
    chk("zero_steps_err", {31'd0, err_o}, 1);
    push_pass(2, 2, 1);
    start(2, 0);
    wait_idle("clear_pass");
    sb.push_back({2'd2, 20'd0});
    start(17, 0);
    wait_idle("too_many_steps");
    chk("too_many_err", {31'd0, err_o}, 1);
    // table write and start while busy are ignored
    base = mux_cnt;
    push_pass(3, 3, 1);
    start(3, 0);
    wait_cnt(0, base + 1);
    wr(0, 16'hFFFF, 0);
    start(2, 1);
    wait_idle("busy_ignore");
    push_pass(3, 3, 1);
    start(3, 0);
    wait_idle("table_unchanged");
    // asynchronous reset during WaitMeas
    base = meas_cnt;
    meas_resp = 0;
    push_pass(3, 3, 1);
    start(3, 0);
    wait_cnt(1, base + 1);
    @(posedge clk_i);
    #2 rst_i = 1;
    #1 chk("async_reset_outputs", {7'd0, w_outs}, 0);
    sb.delete();
    meas_resp = 1;
    @(posedge clk_i);
    #1 rst_i = 0;
    push_pass(3, 3, 1);
    start(3, 0);
    wait_idle("after_reset");
    // randomized tables, lengths and loop/abort runs
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 16; a++) wr(a, 16'($urandom), 1);
      ns = $urandom_range(1, 16);
      if (r % 2 == 0) begin
        push_pass(ns, ns, 1);
        start(ns, 0);
        wait_idle("rand_pass");
      end else begin
        nrun = ns + $urandom_range(1, 5);
        base = mux_cnt;
        push_pass(ns, nrun, 0);
        start(ns, 1);
        wait_cnt(0, base + nrun);
        abort_now(tab[(nrun - 1) % ns]);
      end
    end
    chk("final_sb", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Scheduler that steps the 4-channel analog mux SPI interface through a programmable table of TX1/TX2/RX1/RX2 address combinations. For each step it:
- triggers the mux interface and waits for its done;
- waits a programmable settle time;
- fires one measurement strobe and waits for the measurement done.

It sits between the host/config logic and the mux SPI interface. It supports single-pass and continuous-loop scans.

Parameters:
DEPTH, 16, number of table entries (power of 2, max 16)
SETTLE_CYCLES, 500, clk_i cycles between mux done and measurement start (0 = no settle wait)
TIMEOUT_CYCLES, 65535, max cycles waiting for mux_done_i or meas_done_i before error

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
cfg_we_i  in  1  table write strobe
cfg_addr_i  in  4  table write index
cfg_data_i  in  16  entry: [15:12] TX1, [11:8] TX2, [7:4] RX1, [3:0] RX2
num_steps_i  in  5  steps per pass, 1..DEPTH, sampled at start
loop_i  in  1  1 = restart at step 0 after last step, sampled at start
start_i  in  1  start scan (single-cycle pulse)
abort_i  in  1  stop scan
busy_o  out  1  high in any state except Idle
done_o  out  1  one-cycle pulse on normal completion of a non-loop pass
err_o  out  1  sticky timeout/config error, cleared by the next accepted start
step_o  out  4  index of the current step
mux_en_o  out  1  one-cycle request to the mux interface
mux_done_i  in  1  mux interface done pulse
TX1_addr_o, TX2_addr_o, RX1_addr_o, RX2_addr_o  out  4 each  mux addresses, registered
meas_start_o  out  1  one-cycle measurement trigger
meas_done_i  in  1  measurement complete pulse

Behaviour:
- Reset (asynchronous, active-high): state Idle; all outputs 0; step, settle and timeout counters 0. Table contents are not reset.
- Table: a write occurs on cfg_we_i in Idle only; writes while busy_o=1 are ignored. cfg_addr_i >= DEPTH is ignored.
- States: Idle, Load, WaitMux, Settle, Measure, WaitMeas, Next, Done, Error.
- Idle:
  - start_i with num_steps_i in 1..DEPTH: latch num_steps_i and loop_i, step=0, clear err_o, go to Load.
  - start_i with num_steps_i = 0 or > DEPTH: go to Error.
- Load (1 cycle): address outputs take table[step] on entry and are held stable through Next. mux_en_o=1 for this cycle only. Go to WaitMux.
- WaitMux:
  - mux_done_i: go to Settle.
  - Timeout counter reaches TIMEOUT_CYCLES: go to Error.
- Settle: count SETTLE_CYCLES cycles, then go to Measure. If SETTLE_CYCLES = 0, go to Measure on the next cycle.
- Measure (1 cycle): meas_start_o=1. Go to WaitMeas.
- WaitMeas:
  - meas_done_i: go to Next.
  - Timeout: go to Error.
- Next (1 cycle):
  - step < num_steps-1: step+1, go to Load.
  - Last step with loop=1: step=0, go to Load.
  - Last step with loop=0: go to Done.
- Done (1 cycle): done_o=1, then Idle.
- Error (1 cycle): err_o set (sticky), then Idle. done_o is not pulsed.
- Timeout counter clears on entry to WaitMux and to WaitMeas. A done input arriving in the same cycle as the timeout is treated as success.
- mux_done_i and meas_done_i are ignored outside their wait states.
- abort_i in any non-Idle state: next state is Idle. No done_o, err_o unchanged, address outputs hold last value. abort_i wins over all other events in that cycle.
- start_i while busy is ignored. start_i and abort_i together in Idle: abort wins, start ignored.
- Latency per step with immediate done responses: Load(1) + WaitMux(1) + SETTLE_CYCLES + Measure(1) + WaitMeas(1) + Next(1).

Test Plan:
- Load entries 0..2 = 0x1234, 0x5678, 0x9ABC; num_steps=3, loop=0, SETTLE_CYCLES=4; mux/meas done responders with 3-cycle delay -> three mux_en_o pulses with addresses (1,2,3,4),(5,6,7,8),(9,A,B,C); each meas_start_o exactly 5 cycles after its mux_done_i; one done_o; busy_o drops the cycle after done_o.
- Same table, loop=1, run 7 steps then abort -> step_o sequence 0,1,2,0,1,2,0; Idle the cycle after abort; no done_o; addresses hold (1,2,3,4).
- mux_done_i never asserted, TIMEOUT_CYCLES=20 -> err_o=1 about 21 cycles after mux_en_o; Idle; next start clears err_o.
- start with num_steps_i=0 -> err_o=1; no mux_en_o.
- cfg_we_i to entry 0 during a scan -> table unchanged (next pass still drives 0x1234); start_i pulsed mid-scan -> ignored.
- Assert rst_i asynchronously mid-WaitMeas -> all outputs 0 immediately, before the next clk_i edge; after release, a scan runs normally from step 0.
